// File: rtl/line_rd_ctrl.sv
// Line-buffer read controller: streams one line of pixels from an SDP RAM
// into a small skid FIFO feeding a valid/ready output with a last marker.
module line_rd_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  line_start,
  input  logic [ADDR_WIDTH-1:0] line_base,
  input  logic [ADDR_WIDTH:0]   line_len,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  line_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW:0]         DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, last_addr_reg;
  logic [ADDR_WIDTH:0]   remain_reg;
  logic                  inflight_reg, inflight_last_reg, line_done_reg;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;

  logic                  start_ok, issue, push, pop, pop_last;
  logic [CW:0]           occupancy;
  logic [DATA_WIDTH:0]   head;

  assign start_ok  = line_start && (line_len != '0) && (line_len <= MAX_LEN);
  assign occupancy = {1'b0, count_reg} + (CW + 1)'(inflight_reg);
  assign head      = mem[rd_ptr_reg];
  assign push      = inflight_reg;
  assign pop       = m_valid && m_ready;
  assign pop_last  = pop && head[DATA_WIDTH];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE:  if (start_ok) state_next = READ;
      READ: begin
        if (occupancy < DEPTH_C) begin
          issue = 1'b1;
          if (remain_reg == (ADDR_WIDTH + 1)'(1)) state_next = DRAIN;
        end
      end
      DRAIN: if (pop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The issued address appears combinationally so the RAM sees it in the
  // issue cycle; otherwise the previously issued address is held.
  assign ram_rd_addr = issue ? cur_addr_reg : last_addr_reg;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cur_addr_reg      <= '0;
      last_addr_reg     <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      line_done_reg     <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
    end else begin
      if (state_reg == IDLE && start_ok) begin
        cur_addr_reg <= line_base;
        remain_reg   <= line_len;
      end else if (issue) begin
        cur_addr_reg  <= cur_addr_reg + 1'b1;
        remain_reg    <= remain_reg - 1'b1;
        last_addr_reg <= cur_addr_reg;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remain_reg == (ADDR_WIDTH + 1)'(1));
      line_done_reg     <= (state_reg == DRAIN) && pop_last;

      if (push) begin
        if (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) wr_ptr_reg <= '0;
        else                                   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        if (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) rd_ptr_reg <= '0;
        else                                   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy gating keeps stale entries hidden.
  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr_reg] <= {inflight_last_reg, ram_rd_data};
  end

  assign busy      = (state_reg != IDLE);
  assign m_valid   = (count_reg != '0);
  assign m_data    = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid && head[DATA_WIDTH];
  assign line_done = line_done_reg;

endmodule
